// File: rtl/dac_pkg.sv
// Shared widths and sample-format helpers for the DAC feeder and the R2R+PWM core.
// Helpers take and return 64-bit values; callers size-cast to their own widths.
package dac_pkg;

  localparam int DEF_R2R_BITS   = 4;
  localparam int DEF_PWM_BITS   = 12;
  localparam int DEF_IN_BITS    = 16;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_CNT_BITS   = 16;

  function automatic int dac_bits(input int r2r, input int pwm);
    return r2r + pwm;
  endfunction

  function automatic logic [63:0] midscale(input int bits);
    return 64'd1 << (bits - 1);
  endfunction

  // Signed two's complement -> offset binary, then left-align or truncate to dac_width.
  function automatic logic [63:0] to_offset_binary(input logic [63:0] s, input int in_width,
                                                   input int dac_width);
    logic [63:0] ob;
    ob = s & ((64'd1 << in_width) - 64'd1);
    ob = ob ^ (64'd1 << (in_width - 1));
    if (in_width >= dac_width) return ob >> (in_width - dac_width);
    else return ob << (dac_width - in_width);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head and an occupancy count.
// Full/empty come from level; the caller guarantees no push when full or pop when empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;

  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + PTR_ONE;
      if (pop)  r_rptr <= r_rptr + PTR_ONE;
      if (push && !pop)      r_level <= r_level + LVL_ONE;
      else if (pop && !push) r_level <= r_level - LVL_ONE;
    end
  end

  assign rdata = r_mem[r_rptr];
  assign level = r_level;

endmodule

// File: rtl/dac_sample_feeder.sv
// Buffers signed PCM samples and serves one offset-binary value per DAC frame,
// holding the last value and counting starved frames when the buffer runs dry.
module dac_sample_feeder import dac_pkg::*; #(
  parameter int R2R_BITS   = DEF_R2R_BITS,
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int IN_BITS    = DEF_IN_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_BITS   = DEF_CNT_BITS
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_BITS-1:0]              in_data,
  input  logic                            val_req,
  output logic [R2R_BITS+PWM_BITS-1:0]    dac_val,
  output logic                            underrun,
  output logic [CNT_BITS-1:0]             underrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int DAC_BITS = dac_bits(R2R_BITS, PWM_BITS);
  localparam int LW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DAC_BITS-1:0] MID      = DAC_BITS'(midscale(DAC_BITS));
  localparam logic [LW-1:0]       LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};

  logic                r_ready_en;
  logic [DAC_BITS-1:0] r_dac_val;
  logic                r_underrun;
  logic [CNT_BITS-1:0] r_cnt;

  logic [IN_BITS-1:0]  w_head;
  logic [LW-1:0]       w_level;
  logic [DAC_BITS-1:0] w_conv;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_starve;

  // in_ready depends only on level, flush and reset state; never on val_req.
  assign w_empty  = (w_level == '0);
  assign in_ready = r_ready_en & (w_level != LVL_FULL) & ~flush;
  assign w_push   = in_valid & in_ready;
  assign w_pop    = val_req & ~flush & ~w_empty;
  assign w_starve = val_req & ~flush & w_empty;
  assign w_conv   = DAC_BITS'(to_offset_binary(64'(w_head), IN_BITS, DAC_BITS));

  sync_fifo #(
    .WIDTH (IN_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (flush),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (in_data),
    .rdata (w_head),
    .level (w_level)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ready_en <= 1'b0;
      r_dac_val  <= MID;
      r_underrun <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_underrun <= w_starve;
      if (flush)      r_dac_val <= MID;
      else if (w_pop) r_dac_val <= w_conv;
      if (w_starve && r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign dac_val      = r_dac_val;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_cnt;
  assign fifo_level   = w_level;

endmodule
